// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IM port, stall hold, redirect.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 14,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_stall,
    input  logic             IM_stall,
    input  logic             IM_flush,
    input  logic [1:0]       branch_ctrl,
    input  logic [31:0]      pc_imm_target,
    input  logic [31:0]      pc_reg_target,
    input  logic [31:0]      im_rdata,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_oe,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic             if_valid,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      flush_cnt
);

    typedef enum logic {S_RUN, S_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_im_oe;
    logic        r_pend_v;
    logic [31:0] r_pend_pc;
    logic [31:0] r_tag_pc;
    logic        r_tag_live;
    logic        r_hold_v;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_if_valid;

    logic        w_redirect;
    logic        w_issue;
    logic [31:0] w_target;
    logic [31:0] w_pc_nxt;
    logic        w_pend_v_nxt;
    logic [31:0] w_pend_pc_nxt;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_inst;
    logic        w_out_valid;
    logic        w_hold_v_nxt;
    logic [31:0] w_hold_pc_nxt;
    logic [31:0] w_hold_inst_nxt;

    assign w_redirect = (branch_ctrl != 2'b00);
    assign w_issue    = r_im_oe && !IM_stall;

    assign im_addr  = r_pc[IM_AW+1:2];
    assign im_oe    = r_im_oe;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;
    assign if_valid = r_if_valid;

    // Select the redirect target from EX.
    always_comb begin
        w_target = pc_imm_target;
        unique case (branch_ctrl)
            2'b01:   w_target = pc_imm_target;
            2'b10:   w_target = pc_reg_target;
            2'b11:   w_target = {pc_reg_target[31:1], 1'b0};
            default: w_target = pc_imm_target;
        endcase
    end

    // Next PC and pending-redirect bookkeeping, newest redirect wins.
    always_comb begin
        w_pc_nxt      = r_pc;
        w_pend_v_nxt  = r_pend_v;
        w_pend_pc_nxt = r_pend_pc;
        if (w_redirect && !PC_stall) begin
            w_pc_nxt     = w_target;
            w_pend_v_nxt = 1'b0;
        end else if (w_redirect) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = w_target;
        end else if (r_pend_v && !PC_stall) begin
            w_pc_nxt     = r_pend_pc;
            w_pend_v_nxt = 1'b0;
        end else if (!PC_stall && w_issue) begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    // PC, pending redirect and IM enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_im_oe   <= 1'b0;
            r_pend_v  <= 1'b0;
            r_pend_pc <= 32'h0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_im_oe   <= 1'b1;
            r_pend_v  <= w_pend_v_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    // Tag of the fetch in flight; a flush kills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_pc   <= 32'h0;
            r_tag_live <= 1'b0;
        end else if (w_issue) begin
            r_tag_pc   <= r_pc;
            r_tag_live <= !IM_flush;
        end else if (IM_flush) begin
            r_tag_live <= 1'b0;
        end
    end

    // Hold-path state: S_HOLD means the previous cycle was an IM stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    // Delivered entry and hold register selection.
    always_comb begin
        w_state_nxt     = IM_stall ? S_HOLD : S_RUN;
        w_out_pc        = r_if_pc;
        w_out_inst      = r_if_inst;
        w_out_valid     = r_if_valid;
        w_hold_v_nxt    = r_hold_v;
        w_hold_pc_nxt   = r_hold_pc;
        w_hold_inst_nxt = r_hold_inst;
        unique case (r_state)
            S_RUN: begin
                w_out_pc    = r_tag_pc;
                w_out_valid = r_tag_live && !(IM_stall && IM_flush);
                w_out_inst  = w_out_valid ? im_rdata : NOP_INST;
                if (IM_stall) begin
                    w_hold_v_nxt    = w_out_valid;
                    w_hold_pc_nxt   = r_tag_pc;
                    w_hold_inst_nxt = im_rdata;
                end
            end
            S_HOLD: begin
                if (IM_stall) begin
                    if (IM_flush) begin
                        w_hold_v_nxt = 1'b0;
                        w_out_valid  = 1'b0;
                        w_out_inst   = NOP_INST;
                    end
                end else begin
                    w_out_pc     = r_hold_pc;
                    w_out_valid  = r_hold_v && !IM_flush;
                    w_out_inst   = w_out_valid ? r_hold_inst : NOP_INST;
                    w_hold_v_nxt = 1'b0;
                end
            end
            default: begin
                w_out_valid = 1'b0;
                w_out_inst  = NOP_INST;
            end
        endcase
    end

    // Hold and IF output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v    <= 1'b0;
            r_hold_pc   <= 32'h0;
            r_hold_inst <= NOP_INST;
            r_if_pc     <= 32'h0;
            r_if_inst   <= NOP_INST;
            r_if_valid  <= 1'b0;
        end else begin
            r_hold_v    <= w_hold_v_nxt;
            r_hold_pc   <= w_hold_pc_nxt;
            r_hold_inst <= w_hold_inst_nxt;
            r_if_pc     <= w_out_pc;
            r_if_inst   <= w_out_inst;
            r_if_valid  <= w_out_valid;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_fetch_inc;

    // Hold repeats (S_HOLD) are not new fetches.
    assign w_fetch_inc = (r_state == S_RUN) && w_out_valid;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (IM_flush)    r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign fetch_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule
